// File: rtl/sbox_share_arbiter.sv
// Round-robin sharing of one external AES Sbox between N_REQ byte requesters,
// with a tag pipeline that follows the Sbox latency and per-requester result holding.
// Optional build macro SBOX_ARB_STATS_EN adds a saturating lookup counter output.
module sbox_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int SBOX_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [8*N_REQ-1:0]   req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [8*N_REQ-1:0]   resp_data,
  input  logic [N_REQ-1:0]     resp_ready,
  output logic [7:0]           Sbox_in,
  input  logic [7:0]           Sbox_out
`ifdef SBOX_ARB_STATS_EN
  ,
  output logic [15:0]          lookup_cnt
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N_REQ - 1);

  logic [IW-1:0]    ptr;
  logic [N_REQ-1:0] busy;
  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] resp_hs;
  logic             grant_any;
  logic             grant;
  logic [IW-1:0]    grant_idx;
  logic [IW-1:0]    next_ptr;
  logic             tag_v;
  logic [IW-1:0]    tag_id;

  assign eligible = req_valid & ~busy;
  assign resp_hs  = resp_valid & resp_ready;
  // Reset blocks any grant so nothing enters the pipeline while rst is high.
  assign grant    = grant_any & ~rst;
  assign next_ptr = (grant_idx == LAST_IDX) ? '0 : grant_idx + IW'(1);

  always_comb begin : grant_search
    int cand;
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= N_REQ) cand = cand - N_REQ;
      if (!grant_any && eligible[IW'(cand)]) begin
        grant_any = 1'b1;
        grant_idx = IW'(cand);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    Sbox_in   = 8'h00;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant && grant_idx == IW'(i)) begin
        req_ready[i] = 1'b1;
        Sbox_in      = req_data[8*i +: 8];
      end
    end
  end

  generate
    if (SBOX_LAT == 0) begin : g_tag_comb
      assign tag_v  = grant;
      assign tag_id = grant_idx;
    end else begin : g_tag_pipe
      logic [SBOX_LAT-1:0] pipe_v;
      logic [IW-1:0]       pipe_id [SBOX_LAT];

      always_ff @(posedge clk) begin
        if (rst) begin
          pipe_v <= '0;
          for (int s = 0; s < SBOX_LAT; s++) pipe_id[s] <= '0;
        end else begin
          pipe_v[0]  <= grant;
          pipe_id[0] <= grant_idx;
          for (int s = 1; s < SBOX_LAT; s++) begin
            pipe_v[s]  <= pipe_v[s-1];
            pipe_id[s] <= pipe_id[s-1];
          end
        end
      end

      assign tag_v  = pipe_v[SBOX_LAT-1];
      assign tag_id = pipe_id[SBOX_LAT-1];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr        <= '0;
      busy       <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      if (grant) ptr <= next_ptr;
      for (int i = 0; i < N_REQ; i++) begin
        // busy blocks re-grant while a result is pending, so set and clear never collide.
        if (grant && grant_idx == IW'(i))
          busy[i] <= 1'b1;
        else if (resp_hs[i])
          busy[i] <= 1'b0;

        if (tag_v && tag_id == IW'(i)) begin
          resp_valid[i]       <= 1'b1;
          resp_data[8*i +: 8] <= Sbox_out;
        end else if (resp_hs[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

`ifdef SBOX_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst)
      lookup_cnt <= '0;
    else if (grant && lookup_cnt != 16'hFFFF)
      lookup_cnt <= lookup_cnt + 16'd1;
  end
`endif

endmodule
